// File: rtl/bsg_adder_prefix_pipelined.sv
// Pipelined Kogge-Stone adder with valid/ready stages; the prefix tree is cut into stages_p registers.
// Define BSG_ADDER_PREFIX_PIPELINED_SUB_EN to add a sub_i input selecting A-B.
module bsg_adder_prefix_pipelined #(
  parameter int width_p  = 32,
  parameter int stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               c_i,
`ifdef BSG_ADDER_PREFIX_PIPELINED_SUB_EN
  input  logic               sub_i,
`endif
  output logic               v_o,
  input  logic               ready_i,
  output logic [width_p-1:0] sum_o,
  output logic               c_o,
  output logic               ovf_o
);

  localparam int levels_lp = $clog2(width_p);

  if (width_p < 2 || stages_p < 1 || stages_p > levels_lp + 1) begin : g_param_err
    $error("bsg_adder_prefix_pipelined: illegal width_p/stages_p");
  end

  // Node n of gg/pp is bit n-1; node 0 is the carry-in (bit -1).
  typedef struct packed {
    logic [width_p-1:0] p;
    logic [width_p-1:0] gg;
    logic [width_p-1:0] pp;
    logic               g_msb;
  } pg_t;

  function automatic int cut_f(input int k);
    return ((k + 1) * (levels_lp + 1) + stages_p - 1) / stages_p - 1;
  endfunction

  function automatic pg_t prefix_levels(input pg_t s, input int lo, input int hi);
    pg_t r;
    pg_t t;
    r = s;
    for (int j = 0; j < levels_lp; j++) begin
      if (j >= lo && j <= hi) begin
        t = r;
        for (int n = 0; n < width_p; n++) begin
          if (n >= (1 << j)) begin
            t.gg[n] = r.gg[n] | (r.pp[n] & r.gg[n - (1 << j)]);
            t.pp[n] = r.pp[n] & r.pp[n - (1 << j)];
          end
        end
        r = t;
      end
    end
    return r;
  endfunction

  // Returns {ovf, carry_out, sum} from a fully resolved prefix state.
  function automatic logic [width_p+1:0] finish_sum(input pg_t s);
    logic co;
    co = s.g_msb | (s.p[width_p-1] & s.gg[width_p-1]);
    return {co ^ s.gg[width_p-1], co, s.p ^ s.gg};
  endfunction

  logic [width_p-1:0] b_eff;
  logic               c_eff;
  logic [width_p-1:0] p_bit;
  logic [width_p-1:0] g_bit;

`ifdef BSG_ADDER_PREFIX_PIPELINED_SUB_EN
  assign b_eff = sub_i ? ~b_i : b_i;
  assign c_eff = sub_i ? 1'b1 : c_i;
`else
  assign b_eff = b_i;
  assign c_eff = c_i;
`endif

  assign p_bit = a_i ^ b_eff;
  assign g_bit = a_i & b_eff;

  pg_t pg_in [stages_p];

  assign pg_in[0] = '{p:     p_bit,
                      gg:    {g_bit[width_p-2:0], c_eff},
                      pp:    {p_bit[width_p-2:0], 1'b0},
                      g_msb: g_bit[width_p-1]};

  logic [stages_p-1:0] valid_q;
  logic [stages_p-1:0] valid_d;
  logic [stages_p-1:0] load;
  logic [stages_p:0]   adv;

  // An empty stage always advances, so bubbles collapse under a stalled output.
  always_comb begin
    adv = '0;
    adv[stages_p] = ready_i;
    for (int k = stages_p - 1; k >= 0; k--) begin
      adv[k] = ~valid_q[k] | adv[k+1];
    end
    load    = '0;
    load[0] = adv[0] & v_i;
    valid_d = valid_q;
    if (adv[0]) valid_d[0] = v_i;
    for (int k = 1; k < stages_p; k++) begin
      load[k] = adv[k] & valid_q[k-1];
      if (adv[k]) valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) valid_q <= '0;
    else            valid_q <= valid_d;
  end

  assign ready_o = adv[0];
  assign v_o     = valid_q[stages_p-1];

  for (genvar k = 0; k < stages_p; k++) begin : g_stage
    localparam int lo_lp = cut_f(k - 1) + 1;
    localparam int hi_lp = cut_f(k);

    if (k < stages_p - 1) begin : g_mid
      pg_t pg_d;
      pg_t pg_q;

      always_comb begin
        pg_d = pg_q;
        if (load[k]) pg_d = prefix_levels(pg_in[k], lo_lp, hi_lp);
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) pg_q <= '0;
        else            pg_q <= pg_d;
      end

      assign pg_in[k+1] = pg_q;
    end else begin : g_last
      logic [width_p+1:0] res_d;
      logic [width_p+1:0] res_q;

      always_comb begin
        res_d = res_q;
        if (load[k]) res_d = finish_sum(prefix_levels(pg_in[k], lo_lp, levels_lp - 1));
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) res_q <= '0;
        else            res_q <= res_d;
      end

      assign sum_o = res_q[width_p-1:0];
      assign c_o   = res_q[width_p];
      assign ovf_o = res_q[width_p+1];
    end
  end

endmodule

// File: tb/tb_bsg_adder_prefix_pipelined.sv
// Bench for bsg_adder_prefix_pipelined: directed 8-bit checks plus randomized 16-bit sweeps
// at stages_p 1, 3 and 5 against an arithmetic reference model.
module tb_bsg_adder_prefix_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n;
  logic rst16_n;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Returns {ovf, carry_out, sum[15:0]} for a w-bit add or subtract.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic sub);
    longint msk, aa, bb, full, sm;
    logic co, ovf;
    logic [17:0] r;
    msk  = (longint'(1) << w) - 1;
    aa   = longint'(a) & msk;
    bb   = sub ? (~longint'(b)) & msk : longint'(b) & msk;
    full = aa + bb + (sub ? longint'(1) : longint'(c));
    sm   = full & msk;
    co   = full[w];
    ovf  = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
    r        = '0;
    r[15:0]  = sm[15:0];
    r[16]    = co;
    r[17]    = ovf;
    return r;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- 8-bit, 2-stage directed instance ----------------
  logic       v8, rdy8_o, c8, vo8, rdy8_i, co8, ovf8, sub8;
  logic [7:0] a8, b8, sum8;

  bsg_adder_prefix_pipelined #(.width_p(8), .stages_p(2)) u_dut8 (
    .clk_i     (clk),
    .reset_n_i (rst8_n),
    .v_i       (v8),
    .ready_o   (rdy8_o),
    .a_i       (a8),
    .b_i       (b8),
    .c_i       (c8),
`ifdef BSG_ADDER_PREFIX_PIPELINED_SUB_EN
    .sub_i     (sub8),
`endif
    .v_o       (vo8),
    .ready_i   (rdy8_i),
    .sum_o     (sum8),
    .c_o       (co8),
    .ovf_o     (ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    v8 = v; a8 = a; b8 = b; c8 = c;
  endtask

  task automatic chk_out8(input string nm, input logic v, input logic [7:0] s,
                          input logic c, input logic o);
    chk({nm, "_v"},   {31'd0, vo8},   {31'd0, v});
    chk({nm, "_sum"}, {24'd0, sum8},  {24'd0, s});
    chk({nm, "_c"},   {31'd0, co8},   {31'd0, c});
    chk({nm, "_ovf"}, {31'd0, ovf8},  {31'd0, o});
  endtask

  // ---------------- 16-bit randomized instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 3 : 5;

    logic        v, rdy_o, c, vo, rdy_i, co, ovf, sub;
    logic [15:0] a, b, sum;
    bit          done = 1'b0;

    bsg_adder_prefix_pipelined #(.width_p(16), .stages_p(S)) u_dut (
      .clk_i     (clk),
      .reset_n_i (rst16_n),
      .v_i       (v),
      .ready_o   (rdy_o),
      .a_i       (a),
      .b_i       (b),
      .c_i       (c),
`ifdef BSG_ADDER_PREFIX_PIPELINED_SUB_EN
      .sub_i     (sub),
`endif
      .v_o       (vo),
      .ready_i   (rdy_i),
      .sum_o     (sum),
      .c_o       (co),
      .ovf_o     (ovf)
    );

    logic [17:0] q_exp [$];
    int          q_acc [$];

    initial begin
      int cyc;
      int nacc;
      int stall;
      bit hold;
      string tag;
      cyc = 0; nacc = 0; stall = 0; hold = 1'b0;
      tag = $sformatf("rand_s%0d", S);
      v = 1'b0; a = '0; b = '0; c = 1'b0; sub = 1'b0; rdy_i = 1'b0;
      wait (rst16_n === 1'b1);
      @(posedge clk);
      #1;
      while (nacc < 10000 && cyc < 40000) begin
        if (!hold) begin
          v = ($urandom_range(0, 9) < 7);
          a = pick_operand();
          b = pick_operand();
          c = 1'($urandom_range(0, 1));
`ifdef BSG_ADDER_PREFIX_PIPELINED_SUB_EN
          sub = 1'($urandom_range(0, 1));
`endif
        end
        if (stall > 0) begin
          rdy_i = 1'b0;
          stall--;
        end else if ($urandom_range(0, 19) == 0) begin
          rdy_i = 1'b0;
          stall = $urandom_range(1, 8);
        end else begin
          rdy_i = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        chk({tag, "_ready_o"}, {31'd0, rdy_o},
            {31'd0, (q_exp.size() < S) || rdy_i});
        chk({tag, "_v_o"}, {31'd0, vo},
            {31'd0, (q_exp.size() > 0) && (q_acc[0] + S <= cyc)});
        if (vo && q_exp.size() > 0) begin
          chk({tag, "_result"}, {14'd0, ovf, co, sum}, {14'd0, q_exp[0]});
          if (rdy_i) begin
            void'(q_exp.pop_front());
            void'(q_acc.pop_front());
          end
        end
        if (v && rdy_o) begin
          q_exp.push_back(ref_add(16, a, b, c, sub));
          q_acc.push_back(cyc);
          nacc++;
        end
        hold = v && !rdy_o;

        @(posedge clk);
        cyc++;
        #1;
      end
      v = 1'b0;
      rdy_i = 1'b1;
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    rst8_n = 1'b0; rst16_n = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; rdy8_i = 1'b0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out8("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_ready_o", {31'd0, rdy8_o}, 32'd1);
    @(negedge clk);
    rst8_n = 1'b1; rst16_n = 1'b1;
    tick();

    // latency: 0x7F + 0x01
    rdy8_i = 1'b1;
    drive8(1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    chk("lat_early_v", {31'd0, vo8}, 32'd0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk_out8("lat", 1'b1, 8'h80, 1'b0, 1'b1);
    tick();
    chk("lat_after_v", {31'd0, vo8}, 32'd0);

    // back-to-back
    drive8(1'b1, 8'hFF, 8'h01, 1'b1);
    tick();
    drive8(1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    chk_out8("b2b0", 1'b1, 8'h01, 1'b1, 1'b0);
    drive8(1'b1, 8'h55, 8'hAA, 1'b0);
    tick();
    chk_out8("b2b1", 1'b1, 8'h00, 1'b0, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk_out8("b2b2", 1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("b2b_end_v", {31'd0, vo8}, 32'd0);

    // stall with three operand sets
    rdy8_i = 1'b0;
    drive8(1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    chk("stall_rdy1", {31'd0, rdy8_o}, 32'd1);
    drive8(1'b1, 8'h10, 8'h20, 1'b1);
    tick();
    chk("stall_rdy2", {31'd0, rdy8_o}, 32'd0);
    chk_out8("stall_hold0", 1'b1, 8'h03, 1'b0, 1'b0);
    drive8(1'b1, 8'h80, 8'h80, 1'b0);
    tick();
    chk("stall_rdy3", {31'd0, rdy8_o}, 32'd0);
    chk_out8("stall_hold1", 1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    chk_out8("stall_hold2", 1'b1, 8'h03, 1'b0, 1'b0);
    rdy8_i = 1'b1;
    #1;
    chk("stall_rdy_release", {31'd0, rdy8_o}, 32'd1);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    chk_out8("stall_out1", 1'b1, 8'h31, 1'b0, 1'b0);
    tick();
    chk_out8("stall_out2", 1'b1, 8'h00, 1'b1, 1'b1);
    tick();
    chk("stall_end_v", {31'd0, vo8}, 32'd0);

    // reset mid-flight
    drive8(1'b1, 8'h11, 8'h22, 1'b0);
    tick();
    drive8(1'b1, 8'h44, 8'h11, 1'b0);
    tick();
    chk_out8("rst_pre", 1'b1, 8'h33, 1'b0, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    rst8_n = 1'b0;
    #1;
    chk_out8("rst_async", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst8_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_stale_v", {31'd0, vo8}, 32'd0);
      chk("rst_ready_o", {31'd0, rdy8_o}, 32'd1);
    end

`ifdef BSG_ADDER_PREFIX_PIPELINED_SUB_EN
    sub8 = 1'b1;
    drive8(1'b1, 8'h10, 8'h20, 1'b0);
    tick();
    drive8(1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    chk_out8("sub0", 1'b1, 8'hF0, 1'b0, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    sub8 = 1'b0;
    tick();
    chk_out8("sub1", 1'b1, 8'h7F, 1'b1, 1'b1);
    tick();
`endif

    guard = 0;
    while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && guard < 60000) begin
      @(posedge clk);
      guard++;
    end
    n_total++;
    if (g_rand[0].done && g_rand[1].done && g_rand[2].done) n_pass++;
    else $display("FAIL rand_timeout: random sweeps not done after %0d cycles", guard);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
